// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt front-end: bus field positions,
// register indices and the debounce counter sizing helper.
package gpio_irq_pkg;

  // Peripheral data bus geometry: 32-bit data, 4 byte strobes, word index in [3:2].
  localparam int X1  = 31;
  localparam int WS  = 3;
  localparam int XRU = 3;
  localparam int XRL = 2;

  typedef enum logic [1:0] {
    GPIO_IRQ_PEND = 2'd0,
    GPIO_IRQ_EN   = 2'd1,
    GPIO_IRQ_RISE = 2'd2,
    GPIO_IRQ_FALL = 2'd3
  } gpio_irq_reg_e;

  // Counter must hold 0..DB_CYCLES-1; never narrower than one bit.
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_sync_db.sv
// One pin: 2-FF synchroniser followed by a consecutive-cycle debounce filter.
// q_stable only changes after the synchronised level has disagreed for DB_CYCLES cycles.
module gpio_sync_db
  import gpio_irq_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q_stable
);

  logic s1;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the 2-FF chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  if (DB_CYCLES == 0) begin : g_bypass
    // Without a filter the second sync flop already is the accepted level,
    // which keeps pin-to-pending latency at two edges.
    assign q_stable = s2;
  end else begin : g_debounce
    localparam int CW = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          stable;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign q_stable = stable;
  end

endmodule

// File: rtl/gpio_irq.sv
// GPIO interrupt front-end: per-pin sync/debounce, edge detect into a W1C
// pending register, enable mask and a 4-word register file on the data bus.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int N         = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          dcs,
  input  logic          drd,
  input  logic          dwe,
  input  logic [WS:0]   dwst,
  input  logic [X1:0]   dadrs,
  input  logic [X1:0]   din,
  output logic [X1:0]   dout,
  output logic          irq,
  input  logic [N-1:0]  pin_in
);

  logic [N-1:0]  stable;
  logic [N-1:0]  prev;
  logic [N-1:0]  pend;
  logic [N-1:0]  en;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;

  gpio_irq_reg_e reg_idx;
  logic          cs;
  logic          wr_en;
  logic [N-1:0]  w1c;
  logic [N-1:0]  edge_ev;
  logic [X1:0]   rd_data;

  for (genvar i = 0; i < N; i++) begin : g_pin
    gpio_sync_db #(
      .DB_CYCLES (DB_CYCLES)
    ) u_sync_db (
      .clk      (clk),
      .rstn     (rstn),
      .d        (pin_in[i]),
      .q_stable (stable[i])
    );
  end

  assign reg_idx = gpio_irq_reg_e'(dadrs[XRU:XRL]);
  assign cs      = dcs & (drd | dwe);
  assign wr_en   = dcs & dwe & dwst[0];
  assign w1c     = (wr_en && reg_idx == GPIO_IRQ_PEND) ? din[N-1:0] : '0;
  assign edge_ev = (stable & ~prev & rise) | (~stable & prev & fall);

  // NOTE: every always_comb target gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    unique case (reg_idx)
      GPIO_IRQ_PEND: rd_data[N-1:0] = pend;
      GPIO_IRQ_EN:   rd_data[N-1:0] = en;
      GPIO_IRQ_RISE: rd_data[N-1:0] = rise;
      GPIO_IRQ_FALL: rd_data[N-1:0] = fall;
      default:       rd_data = '0;
    endcase
  end

  // Events are OR-ed in after the clear mask, so a fresh edge survives a
  // simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev <= '0;
      pend <= '0;
      en   <= '0;
      rise <= '0;
      fall <= '0;
      dout <= '0;
    end else begin
      prev <= stable;
      pend <= (pend & ~w1c) | edge_ev;
      if (wr_en) begin
        unique case (reg_idx)
          GPIO_IRQ_EN:   en   <= din[N-1:0];
          GPIO_IRQ_RISE: rise <= din[N-1:0];
          GPIO_IRQ_FALL: fall <= din[N-1:0];
          default:       ;
        endcase
      end
      if (cs) begin
        dout <= rd_data;
      end
    end
  end

  assign irq = |(pend & en);

  // Address bits outside the word index, upper data bits and upper strobes
  // carry no meaning for this block.
  logic unused_bus;
  assign unused_bus = &{1'b0, dadrs[X1:XRU+1], dadrs[XRL-1:0], din[X1:N], dwst[WS:1]};

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: register table, directed corner cases,
// randomized pins/bus against a window-based reference model, and a DB_CYCLES=0 build.
`timescale 1ns/1ps
module tb_gpio_irq;
  import gpio_irq_pkg::*;

  localparam int N  = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dcs = 1'b0;
  logic        drd = 1'b0;
  logic        dwe = 1'b0;
  logic [3:0]  dwst = '0;
  logic [31:0] dadrs = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [31:0] dout_z;
  logic        irq;
  logic        irq_z;
  logic [7:0]  pin_in = '0;
  logic [7:0]  pin_z = '0;

  always #5 clk = ~clk;

  gpio_irq #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rstn(rstn), .dcs(dcs), .drd(drd), .dwe(dwe), .dwst(dwst),
    .dadrs(dadrs), .din(din), .dout(dout), .irq(irq), .pin_in(pin_in)
  );

  gpio_irq #(.N(N), .DB_CYCLES(0)) dut_z (
    .clk(clk), .rstn(rstn), .dcs(dcs), .drd(drd), .dwe(dwe), .dwst(dwst),
    .dadrs(dadrs), .din(din), .dout(dout_z), .irq(irq_z), .pin_in(pin_z)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the DB=4 instance. A pin's accepted level flips when the
  // last DB synchronised samples (pin values two edges old) all disagree with it.
  logic [7:0]  m_pend, m_en, m_rise, m_fall, m_stable, m_prev;
  logic [31:0] m_dout;
  logic [7:0]  hist[$];

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_rise = '0; m_fall = '0;
    m_stable = '0; m_prev = '0; m_dout = '0;
    hist.delete();
    repeat (16) hist.push_back(8'h00);
  endtask

  task automatic model_step();
    logic [7:0] ev;
    logic [7:0] sel;
    logic [7:0] h;
    logic       all_diff;
    if (!rstn) begin
      model_reset();
      return;
    end
    ev = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
    if (dcs && (drd || dwe)) begin
      case (dadrs[3:2])
        2'd0: sel = m_pend;
        2'd1: sel = m_en;
        2'd2: sel = m_rise;
        default: sel = m_fall;
      endcase
      m_dout = {24'h0, sel};
    end
    if (dcs && dwe && dwst[0]) begin
      case (dadrs[3:2])
        2'd0: m_pend = m_pend & ~din[7:0];
        2'd1: m_en = din[7:0];
        2'd2: m_rise = din[7:0];
        default: m_fall = din[7:0];
      endcase
    end
    m_pend = m_pend | ev;
    m_prev = m_stable;
    for (int b = 0; b < 8; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        h = hist[hist.size() - j];
        if (h[b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    hist.push_back(pin_in);
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] adrs, input logic [31:0] data, input logic [3:0] strb);
    dcs = 1'b1; dwe = 1'b1; drd = 1'b0; dadrs = adrs; din = data; dwst = strb;
    step();
    dcs = 1'b0; dwe = 1'b0; dwst = '0; din = '0; dadrs = '0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] data);
    bus_wr({28'h0, idx, 2'b00}, data, 4'h1);
  endtask

  task automatic bus_rd(input logic [31:0] adrs, output logic [31:0] data);
    dcs = 1'b1; drd = 1'b1; dadrs = adrs;
    step();
    data = dout;
    dcs = 1'b0; drd = 1'b0; dadrs = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd({28'h0, idx, 2'b00}, v);
    check(name, v, exp);
  endtask

  typedef struct {
    logic [31:0] adrs;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rd_adrs;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] v;
    int          p;
    int          op;
    bit          is_rd;

    vecs[0] = '{32'h0000_0004, 32'h0000_00A5, 4'h1, 32'h04, 32'h0000_00A5, "en_write"};
    vecs[1] = '{32'h0000_0008, 32'h0000_003C, 4'hF, 32'h08, 32'h0000_003C, "rise_write"};
    vecs[2] = '{32'h0000_000C, 32'hFFFF_FF0F, 4'h1, 32'h0C, 32'h0000_000F, "fall_upper_din"};
    vecs[3] = '{32'h0000_0004, 32'h0000_00FF, 4'hE, 32'h04, 32'h0000_00A5, "en_no_strobe"};
    vecs[4] = '{32'h0000_0F35, 32'h0000_005A, 4'h1, 32'h04, 32'h0000_005A, "en_alias_addr"};
    vecs[5] = '{32'h0000_0008, 32'h0000_0000, 4'h0, 32'h08, 32'h0000_003C, "rise_no_strobe"};
    vecs[6] = '{32'h0000_0000, 32'h0000_00FF, 4'h1, 32'h00, 32'h0000_0000, "pend_w1c_empty"};
    vecs[7] = '{32'h0000_001C, 32'h0000_0000, 4'h1, 32'h0C, 32'h0000_0000, "fall_alias_clear"};

    model_reset();
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Reset arriving mid-debounce with pins toggling.
    wr(GPIO_IRQ_EN, 32'hFF);
    wr(GPIO_IRQ_RISE, 32'hFF);
    wr(GPIO_IRQ_FALL, 32'hFF);
    pin_in = 8'hFF;
    repeat (2) step();
    rstn = 1'b0;
    #1;
    check("rst_irq_assert", irq, 0);
    for (int i = 0; i < 3; i++) begin
      pin_in = pin_in ^ 8'h55;
      step();
      check("rst_irq_hold", irq, 0);
    end
    pin_in = 8'h00;
    rstn = 1'b1;
    check("rst_dout", dout, 0);
    repeat (8) step();
    check("rst_irq_after", irq, 0);
    rd_chk("rst_pend", GPIO_IRQ_PEND, 0);
    rd_chk("rst_en", GPIO_IRQ_EN, 0);
    rd_chk("rst_rise", GPIO_IRQ_RISE, 0);
    rd_chk("rst_fall", GPIO_IRQ_FALL, 0);

    // Register access table.
    for (int i = 0; i < 8; i++) begin
      bus_wr(vecs[i].adrs, vecs[i].data, vecs[i].strb);
      bus_rd(vecs[i].rd_adrs, v);
      check(vecs[i].name, v, vecs[i].exp);
    end

    // Rising edge latency: pending lands 2+DB edges after the sample edge.
    wr(GPIO_IRQ_EN, 32'h01);
    wr(GPIO_IRQ_RISE, 32'h01);
    wr(GPIO_IRQ_FALL, 32'h00);
    pin_in[0] = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      step();
      check($sformatf("rise_lat_irq_s%0d", s), irq, (s == 7) ? 1 : 0);
    end
    rd_chk("rise_pend", GPIO_IRQ_PEND, 32'h01);
    wr(GPIO_IRQ_PEND, 32'h01);
    check("w1c_irq", irq, 0);
    rd_chk("w1c_pend", GPIO_IRQ_PEND, 32'h00);

    // Glitch shorter than the filter, then a pulse just long enough.
    wr(GPIO_IRQ_EN, 32'h00);
    wr(GPIO_IRQ_RISE, 32'h08);
    wr(GPIO_IRQ_FALL, 32'h08);
    pin_in[3] = 1'b1;
    repeat (3) step();
    pin_in[3] = 1'b0;
    repeat (8) step();
    rd_chk("glitch_pend", GPIO_IRQ_PEND, 32'h00);
    pin_in[3] = 1'b1;
    repeat (4) step();
    pin_in[3] = 1'b0;
    repeat (10) step();
    rd_chk("pulse_pend", GPIO_IRQ_PEND, 32'h08);
    check("pulse_irq_masked", irq, 0);

    // Falling edge polled with EN=0, then enabled afterwards.
    wr(GPIO_IRQ_PEND, 32'hFF);
    wr(GPIO_IRQ_RISE, 32'h00);
    wr(GPIO_IRQ_FALL, 32'h00);
    pin_in[7] = 1'b1;
    repeat (10) step();
    wr(GPIO_IRQ_FALL, 32'h80);
    pin_in[7] = 1'b0;
    repeat (10) step();
    rd_chk("fall_pend", GPIO_IRQ_PEND, 32'h80);
    check("fall_irq_masked", irq, 0);
    wr(GPIO_IRQ_EN, 32'h80);
    check("late_enable_irq", irq, 1);

    // W1C of bit2 on the very edge its new event is latched.
    wr(GPIO_IRQ_RISE, 32'h04);
    pin_in[2] = 1'b1;
    repeat (6) step();
    wr(GPIO_IRQ_PEND, 32'h04);
    rd_chk("collide_pend", GPIO_IRQ_PEND, 32'h84);
    wr(GPIO_IRQ_PEND, 32'h04);
    rd_chk("collide_clear", GPIO_IRQ_PEND, 32'h80);
    check("collide_irq", irq, 1);

    // Randomized pins and bus traffic against the reference model.
    wr(GPIO_IRQ_EN, 32'($urandom_range(0, 255)));
    wr(GPIO_IRQ_RISE, 32'($urandom_range(0, 255)));
    wr(GPIO_IRQ_FALL, 32'($urandom_range(0, 255)));
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 7);
        pin_in[p] = ~pin_in[p];
      end
      op = $urandom_range(0, 9);
      is_rd = 1'b0;
      dadrs = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      if (op == 0) begin
        dcs = 1'b1; dwe = 1'b1; dwst = 4'h1; dadrs = 32'h0;
        din = 32'($urandom_range(0, 255));
      end else if (op == 1) begin
        dcs = 1'b1; dwe = 1'b1; dwst = 4'($urandom_range(0, 15));
        din = $urandom;
      end else if (op <= 4) begin
        dcs = 1'b1; drd = 1'b1; is_rd = 1'b1;
      end else if (op == 5) begin
        dcs = 1'b0; drd = 1'b1; dwe = 1'($urandom_range(0, 1));
      end
      step();
      check("rand_irq", irq, {31'h0, |(m_pend & m_en)});
      check(is_rd ? "rand_read" : "rand_dout_hold", dout, m_dout);
      dcs = 1'b0; drd = 1'b0; dwe = 1'b0; dwst = '0; din = '0; dadrs = '0;
    end

    // DB_CYCLES=0 build: two-edge latency and one-cycle registered readback.
    wr(GPIO_IRQ_EN, 32'h01);
    wr(GPIO_IRQ_RISE, 32'h01);
    wr(GPIO_IRQ_FALL, 32'h00);
    wr(GPIO_IRQ_PEND, 32'hFF);
    pin_z[0] = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      step();
      check($sformatf("db0_irq_s%0d", s), irq_z, (s == 3) ? 1 : 0);
    end
    dcs = 1'b1; drd = 1'b1; dadrs = 32'h0;
    step();
    check("db0_pend_read", dout_z, 32'h01);
    dadrs = 32'h0C;
    #1;
    check("db0_read_latency", dout_z, 32'h01);
    step();
    check("db0_fall_read", dout_z, 32'h00);
    dcs = 1'b0; dadrs = 32'h04;
    step();
    check("db0_dout_hold", dout_z, 32'h00);
    drd = 1'b0; dadrs = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
